// File: rtl/spi_bus_ctrl_if.sv
// rtl/spi_bus_ctrl_if.sv - pin and decision-logic signal bundle for spi_bus_ctrl
interface spi_bus_ctrl_if #(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);
    logic                        cs_in;
    logic                        sclk_in;
    logic                        mosi_in;
    logic                        miso_in;
    logic                        cs_out;
    logic                        sclk_out;
    logic                        mosi_out;
    logic                        miso_out;
    logic                        cmd_next_chunk;
    logic                        cmd_finish;
    logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size;
    logic                        fake_miso_select;
    logic                        fake_mosi_select;
    logic [BUF_SIZE-1:0]         fake_miso_data;
    logic [BUF_SIZE-1:0]         fake_mosi_data;
    logic                        comm_active;
    logic                        bus_ready;
    logic [BUF_SIZE-1:0]         real_miso_data;
    logic [BUF_SIZE-1:0]         real_mosi_data;

    modport slave (
        input  cs_in, sclk_in, mosi_in, miso_in,
        input  cmd_next_chunk, cmd_finish, next_chunk_size,
        input  fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data,
        output cs_out, sclk_out, mosi_out, miso_out,
        output comm_active, bus_ready, real_miso_data, real_mosi_data
    );

    modport master (
        output cs_in, sclk_in, mosi_in, miso_in,
        output cmd_next_chunk, cmd_finish, next_chunk_size,
        output fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data,
        input  cs_out, sclk_out, mosi_out, miso_out,
        input  comm_active, bus_ready, real_miso_data, real_mosi_data
    );
endinterface

// File: rtl/spi_bus_ctrl.sv
// rtl/spi_bus_ctrl.sv - SPI/Microwire chunked capture and fake-drive bus stage
module spi_bus_ctrl #(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int CS_ACTIVE        = 1
) (
    input  logic          sys_clk,
    input  logic          rst,
    spi_bus_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHUNK,
        ST_READY,
        ST_FINISH
    } state_t;

    localparam logic                        CS_LEVEL = 1'(CS_ACTIVE);
    localparam logic [CHUNK_SIZE_WIDTH-1:0] MAX_SIZE = CHUNK_SIZE_WIDTH'(BUF_SIZE);
    localparam logic [CHUNK_SIZE_WIDTH-1:0] ONE      = CHUNK_SIZE_WIDTH'(1);

    logic [1:0]                  cs_sync_q;
    logic [2:0]                  sclk_sync_q;
    logic [1:0]                  mosi_sync_q;
    logic [1:0]                  miso_sync_q;

    state_t                      state_q;
    logic                        comm_active_q;
    logic                        bus_ready_q;
    logic [BUF_SIZE-1:0]         real_mosi_q;
    logic [BUF_SIZE-1:0]         real_miso_q;
    logic [BUF_SIZE-1:0]         fake_mosi_sr_q;
    logic [BUF_SIZE-1:0]         fake_miso_sr_q;
    logic                        sel_mosi_q;
    logic                        sel_miso_q;
    logic [CHUNK_SIZE_WIDTH-1:0] count_q;
    logic [CHUNK_SIZE_WIDTH-1:0] size_q;

    logic                        cs_active;
    logic                        sclk_rise;
    logic                        sclk_fall;
    logic [CHUNK_SIZE_WIDTH-1:0] size_clamped;
    logic [CHUNK_SIZE_WIDTH-1:0] count_inc;

    // Two stages for metastability; the third sclk stage only feeds edge detection.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            miso_sync_q <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], bus.cs_in};
            sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk_in};
            mosi_sync_q <= {mosi_sync_q[0], bus.mosi_in};
            miso_sync_q <= {miso_sync_q[0], bus.miso_in};
        end
    end

    assign cs_active    = (cs_sync_q[1] == CS_LEVEL);
    assign sclk_rise    = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall    = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign size_clamped = (bus.next_chunk_size > MAX_SIZE) ? MAX_SIZE : bus.next_chunk_size;
    assign count_inc    = count_q + ONE;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            comm_active_q  <= 1'b0;
            bus_ready_q    <= 1'b0;
            real_mosi_q    <= '0;
            real_miso_q    <= '0;
            fake_mosi_sr_q <= '0;
            fake_miso_sr_q <= '0;
            sel_mosi_q     <= 1'b0;
            sel_miso_q     <= 1'b0;
            count_q        <= '0;
            size_q         <= '0;
        end else begin
            comm_active_q <= cs_active;
            if (sclk_fall) begin
                fake_mosi_sr_q <= {fake_mosi_sr_q[BUF_SIZE-2:0], 1'b0};
                fake_miso_sr_q <= {fake_miso_sr_q[BUF_SIZE-2:0], 1'b0};
            end
            // A CS release outranks any command arriving in the same cycle.
            if (!cs_active) begin
                state_q     <= ST_IDLE;
                bus_ready_q <= 1'b0;
                sel_mosi_q  <= 1'b0;
                sel_miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_WAIT;
                    ST_WAIT, ST_CHUNK, ST_READY: begin
                        if (bus.cmd_finish) begin
                            bus_ready_q <= 1'b0;
                            state_q     <= ST_FINISH;
                        end else if (bus.cmd_next_chunk) begin
                            bus_ready_q    <= 1'b0;
                            real_mosi_q    <= '0;
                            real_miso_q    <= '0;
                            count_q        <= '0;
                            size_q         <= size_clamped;
                            sel_mosi_q     <= bus.fake_mosi_select;
                            sel_miso_q     <= bus.fake_miso_select;
                            fake_mosi_sr_q <= bus.fake_mosi_data;
                            fake_miso_sr_q <= bus.fake_miso_data;
                            state_q        <= ST_CHUNK;
                        end else if (state_q == ST_CHUNK) begin
                            // Equality before any edge covers the zero-length chunk.
                            if (count_q == size_q) begin
                                bus_ready_q <= 1'b1;
                                state_q     <= ST_READY;
                            end else if (sclk_rise) begin
                                real_mosi_q <= {real_mosi_q[BUF_SIZE-2:0], mosi_sync_q[1]};
                                real_miso_q <= {real_miso_q[BUF_SIZE-2:0], miso_sync_q[1]};
                                count_q     <= count_inc;
                                if (count_inc == size_q) begin
                                    bus_ready_q <= 1'b1;
                                    state_q     <= ST_READY;
                                end
                            end
                        end
                    end
                    ST_FINISH: state_q <= ST_FINISH;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cs_out         = bus.cs_in;
    assign bus.sclk_out       = bus.sclk_in;
    assign bus.mosi_out       = sel_mosi_q ? fake_mosi_sr_q[BUF_SIZE-1] : bus.mosi_in;
    assign bus.miso_out       = sel_miso_q ? fake_miso_sr_q[BUF_SIZE-1] : bus.miso_in;
    assign bus.comm_active    = comm_active_q;
    assign bus.bus_ready      = bus_ready_q;
    assign bus.real_mosi_data = real_mosi_q;
    assign bus.real_miso_data = real_miso_q;
endmodule

// File: tb/tb_spi_bus_ctrl.sv
// tb/tb_spi_bus_ctrl.sv - randomized and directed bench for spi_bus_ctrl against an event-level model
`timescale 1ns/1ps
module tb_spi_bus_ctrl;
    localparam int BUF_SIZE = 9;
    localparam int CSW      = 4;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    spi_bus_ctrl_if #(.BUF_SIZE(BUF_SIZE), .CHUNK_SIZE_WIDTH(CSW)) bus ();

    spi_bus_ctrl #(.BUF_SIZE(BUF_SIZE), .CHUNK_SIZE_WIDTH(CSW), .CS_ACTIVE(1)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hold_until = 0;
    bit   chk_en = 1'b0;
    logic hi_miso;
    logic [23:0] cmp_act, cmp_exp;

    // Event-level model: what the outputs must settle to after each pin event or command.
    bit   m_active, m_ready, m_capt, m_fin, m_sel_miso, m_sel_mosi;
    int   m_size, m_cnt, m_rmosi, m_rmiso;
    logic fq_miso[$];
    logic fq_mosi[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        if (chk_en && cyc >= hold_until) begin
            cmp_exp = {m_active, m_ready, 9'(m_rmosi), 9'(m_rmiso),
                       m_sel_mosi ? ((fq_mosi.size() > 0) ? fq_mosi[0] : 1'b0) : bus.mosi_in,
                       m_sel_miso ? ((fq_miso.size() > 0) ? fq_miso[0] : 1'b0) : bus.miso_in,
                       bus.cs_in, bus.sclk_in};
            cmp_act = {bus.comm_active, bus.bus_ready, bus.real_mosi_data, bus.real_miso_data,
                       bus.mosi_out, bus.miso_out, bus.cs_out, bus.sclk_out};
            checks++;
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL cycle_compare cyc=%0d actual=%h required=%h", cyc, cmp_act, cmp_exp);
            end
        end
        @(posedge sys_clk);
        cyc++;
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic hold(input int k);
        if (hold_until < cyc + k) hold_until = cyc + k;
    endtask

    task automatic model_release();
        m_active = 0; m_ready = 0; m_capt = 0; m_fin = 0; m_sel_miso = 0; m_sel_mosi = 0;
    endtask

    task automatic set_cs(input bit act);
        bus.cs_in = act;
        hold(3);
        if (act) m_active = 1;
        else     model_release();
        wait_cycles(6);
    endtask

    task automatic sclk_rise();
        bus.sclk_in = 1'b1;
        hold(3);
        if (m_capt) begin
            m_rmosi = m_rmosi * 2 + int'(bus.mosi_in);
            m_rmiso = m_rmiso * 2 + int'(bus.miso_in);
            m_cnt++;
            if (m_cnt == m_size) begin m_ready = 1; m_capt = 0; end
        end
    endtask

    task automatic sclk_fall();
        bus.sclk_in = 1'b0;
        hold(3);
        if (fq_miso.size() > 0) void'(fq_miso.pop_front());
        if (fq_mosi.size() > 0) void'(fq_mosi.pop_front());
    endtask

    task automatic clock_bit(input logic mo, input logic mi);
        bus.mosi_in = mo;
        bus.miso_in = mi;
        wait_cycles(2);
        sclk_rise();
        wait_cycles(6);
        hi_miso = bus.miso_out;
        sclk_fall();
        wait_cycles(6);
    endtask

    task automatic command(input bit nxt, input bit fin, input int size, input bit smi, input bit smo,
                           input logic [8:0] dmi, input logic [8:0] dmo);
        bus.cmd_next_chunk   = nxt;
        bus.cmd_finish       = fin;
        bus.next_chunk_size  = 4'(size);
        bus.fake_miso_select = smi;
        bus.fake_mosi_select = smo;
        bus.fake_miso_data   = dmi;
        bus.fake_mosi_data   = dmo;
        hold(2);
        if (m_active && !m_fin) begin
            if (fin) begin
                m_ready = 0; m_capt = 0; m_fin = 1;
            end else if (nxt) begin
                m_ready = 0; m_rmosi = 0; m_rmiso = 0; m_cnt = 0;
                m_size = (size > BUF_SIZE) ? BUF_SIZE : size;
                m_sel_miso = smi; m_sel_mosi = smo;
                fq_miso.delete(); fq_mosi.delete();
                for (int i = BUF_SIZE - 1; i >= 0; i--) begin
                    fq_miso.push_back(dmi[i]);
                    fq_mosi.push_back(dmo[i]);
                end
                if (m_size == 0) m_ready = 1; else m_capt = 1;
            end
        end
        step();
        bus.cmd_next_chunk = 1'b0;
        bus.cmd_finish     = 1'b0;
        wait_cycles(3);
    endtask

    initial begin
        logic [7:0] got;
        logic [8:0] pat;
        rst = 1'b1;
        bus.cs_in = 0; bus.sclk_in = 0; bus.mosi_in = 0; bus.miso_in = 0;
        bus.cmd_next_chunk = 0; bus.cmd_finish = 0; bus.next_chunk_size = '0;
        bus.fake_miso_select = 0; bus.fake_mosi_select = 0;
        bus.fake_miso_data = '0; bus.fake_mosi_data = '0;
        model_release();
        m_rmosi = 0; m_rmiso = 0; m_size = 0; m_cnt = 0;
        wait_cycles(3);
        rst = 1'b0;
        chk("reset_comm_active", bus.comm_active, 0);
        chk("reset_bus_ready", bus.bus_ready, 0);
        chk("reset_real_mosi", bus.real_mosi_data, 0);
        chk("reset_real_miso", bus.real_miso_data, 0);
        chk_en = 1'b1;
        wait_cycles(2);

        // Microwire READ 0x15 in forward mode
        set_cs(1'b1);
        chk("mw_comm_active", bus.comm_active, 1);
        command(1, 0, 3, 0, 0, 9'h000, 9'h000);
        clock_bit(1'b1, 1'b0);
        clock_bit(1'b1, 1'b1);
        bus.mosi_in = 1'b0;
        bus.miso_in = 1'b1;
        wait_cycles(2);
        sclk_rise();
        wait_cycles(2);
        chk("mw_ready_at_2_cycles", bus.bus_ready, 0);
        step();
        chk("mw_ready_at_3_cycles", bus.bus_ready, 1);
        chk("mw_instr_bits", bus.real_mosi_data, 9'h006);
        wait_cycles(3);
        sclk_fall();
        wait_cycles(6);
        command(1, 0, 9, 0, 0, 9'h000, 9'h000);
        pat = 9'h015;
        for (int i = 8; i >= 0; i--) clock_bit(pat[i], 1'($urandom));
        chk("mw_address", bus.real_mosi_data, 9'h015);
        chk("mw_address_ready", bus.bus_ready, 1);

        // Substitute all data bits towards the master
        command(1, 0, 8, 1, 0, 9'h048, 9'h000);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'($urandom), 1'($urandom));
            got = {got[6:0], hi_miso};
        end
        chk("sub_miso_sequence", got, 8'h24);
        chk("sub_ready", bus.bus_ready, 1);
        clock_bit(1'b0, 1'b1);
        set_cs(1'b0);
        chk("sub_release_comm", bus.comm_active, 0);

        // Abort after two of three instruction bits, then a clean frame
        set_cs(1'b1);
        command(1, 0, 3, 0, 0, 9'h000, 9'h000);
        clock_bit(1'b1, 1'b0);
        clock_bit(1'b1, 1'b0);
        set_cs(1'b0);
        chk("abort_comm_active", bus.comm_active, 0);
        wait_cycles(10);
        chk("abort_ready_low", bus.bus_ready, 0);
        set_cs(1'b1);
        command(1, 0, 3, 0, 0, 9'h000, 9'h000);
        clock_bit(1'b1, 1'b0);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b1, 1'b0);
        chk("abort_new_frame", bus.real_mosi_data, 5);
        chk("abort_new_ready", bus.bus_ready, 1);
        set_cs(1'b0);

        // Size 0 together with finish: finish wins, nothing captured
        set_cs(1'b1);
        command(1, 1, 0, 1, 1, 9'h155, 9'h0AA);
        wait_cycles(4);
        chk("fin_ready_low", bus.bus_ready, 0);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b1);
        chk("fin_ready_still_low", bus.bus_ready, 0);
        chk("fin_no_capture", bus.real_mosi_data, 5);
        command(1, 0, 2, 0, 0, 9'h000, 9'h000);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b0, 1'b0);
        chk("fin_ignores_cmd", bus.bus_ready, 0);
        set_cs(1'b0);

        // Chunk size clamp
        set_cs(1'b1);
        command(1, 0, 15, 0, 0, 9'h000, 9'h000);
        pat = 9'h1A5;
        for (int i = 8; i >= 1; i--) clock_bit(pat[i], 1'b0);
        chk("clamp_not_ready_8", bus.bus_ready, 0);
        clock_bit(pat[0], 1'b0);
        chk("clamp_ready_9", bus.bus_ready, 1);
        chk("clamp_data", bus.real_mosi_data, 9'h1A5);

        // CS release and command in the same cycle
        bus.cs_in = 1'b0;
        hold(4);
        model_release();
        wait_cycles(2);
        bus.cmd_next_chunk = 1'b1;
        bus.next_chunk_size = 4'd3;
        step();
        bus.cmd_next_chunk = 1'b0;
        wait_cycles(4);
        chk("relcmd_comm_active", bus.comm_active, 0);
        chk("relcmd_ready", bus.bus_ready, 0);
        set_cs(1'b1);
        clock_bit(1'b0, 1'b0);
        chk("relcmd_data_held", bus.real_mosi_data, 9'h1A5);

        // Reset while driving fake bits
        command(1, 0, 9, 1, 1, 9'h1FF, 9'h1FF);
        clock_bit(1'b0, 1'b0);
        clock_bit(1'b0, 1'b0);
        chk("rst_fake_before", bus.miso_out, 1);
        rst = 1'b1;
        hold(5);
        model_release();
        m_active = 1; m_rmosi = 0; m_rmiso = 0;
        fq_miso.delete(); fq_mosi.delete();
        step();
        rst = 1'b0;
        chk("rst_miso_passthru", bus.miso_out, 0);
        chk("rst_mosi_passthru", bus.mosi_out, 0);
        chk("rst_ready", bus.bus_ready, 0);
        chk("rst_real_mosi", bus.real_mosi_data, 0);
        wait_cycles(6);
        command(1, 0, 2, 0, 0, 9'h000, 9'h000);
        clock_bit(1'b1, 1'b1);
        clock_bit(1'b0, 1'b1);
        chk("rst_after_data", bus.real_miso_data, 3);
        set_cs(1'b0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            set_cs(1'b1);
            for (int c = 0; c < 4; c++) begin
                int r, sz, eff, nb;
                bit ab;
                r  = int'($urandom_range(0, 15));
                sz = int'($urandom_range(0, 15));
                command((r != 0), (r <= 1), sz, 1'($urandom), 1'($urandom), 9'($urandom), 9'($urandom));
                eff = (sz > BUF_SIZE) ? BUF_SIZE : sz;
                ab  = ($urandom_range(0, 5) == 0) && (eff > 0);
                nb  = ab ? int'($urandom_range(0, eff - 1)) : eff + int'($urandom_range(0, 2));
                for (int b = 0; b < nb; b++) clock_bit(1'($urandom), 1'($urandom));
                if (r <= 1 || (ab && $urandom_range(0, 1) == 0)) break;
            end
            set_cs(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
